t_type_param_fifo: RTL and testbench

//  Type-parameterised FIFO that buffers elements of a type passed in as a

---
 rtl/t_type_param_fifo.sv | 99 +++++++++
 tb/tb_t_type_param_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/t_type_param_fifo.sv
// Type-parameterised synchronous FIFO with valid/ready handshakes on both sides.
// Optional producer-contract checker (err port) enabled by T_TYPE_FIFO_CHECK_EN.
module t_type_param_fifo #(
    parameter type elem_t    = logic [7:0],
    parameter int  DEPTH     = 4,
    parameter int  AFULL_THR = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  elem_t                      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output elem_t                      out_data,
    output logic [$clog2(DEPTH):0]     count,
`ifdef T_TYPE_FIFO_CHECK_EN
    output logic                       err,
`endif
    output logic                       almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    elem_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign in_ready    = (count < CW'(DEPTH));
    assign out_valid   = (count != '0);
    assign almost_full = (count >= CW'(AFULL_THR));
    assign out_data    = out_valid ? mem[rd_ptr] : '0;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Storage is deliberately left out of reset; out_data is gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef T_TYPE_FIFO_CHECK_EN
    logic  pending;
    elem_t pending_data;
    logic  violation;

    // A push is pending when the producer offered data that was not accepted.
    assign violation = pending && (!in_valid || (in_data != pending_data));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= 1'b0;
            pending_data <= '0;
            err          <= 1'b0;
        end else begin
            pending      <= in_valid & ~in_ready;
            pending_data <= in_data;
            if (violation) begin
                err <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && violation && !err) begin
            $display("%%Error: t_type_param_fifo protocol");
            $stop;
        end
    end
`endif
`endif

endmodule

// File: tb/tb_t_type_param_fifo.sv
// Self-checking bench for t_type_param_fifo: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_t_type_param_fifo;

    typedef struct packed {
        logic [3:0] tag;
        logic [7:0] v;
    } pair_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] count;
    logic       almost_full;

    logic       s_in_valid = 1'b0;
    logic       s_in_ready;
    pair_t      s_in_data = '0;
    logic       s_out_valid;
    logic       s_out_ready = 1'b0;
    pair_t      s_out_data;
    logic [3:0] s_count;
    logic       s_almost_full;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [7:0] q [$];
    pair_t      sq [$];

    always #5 clk = ~clk;

    t_type_param_fifo #(
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .count(count),
        .almost_full(almost_full)
    );

    t_type_param_fifo #(
        .elem_t(pair_t),
        .DEPTH(8)
    ) dut_s (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(s_in_valid),
        .in_ready(s_in_ready),
        .in_data(s_in_data),
        .out_valid(s_out_valid),
        .out_ready(s_out_ready),
        .out_data(s_out_data),
        .count(s_count),
        .almost_full(s_almost_full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs follow directly from the model queue contents.
    task automatic check_all(input string tag);
        int unsigned n;
        n = q.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
        chk({tag, ".out_data"}, 32'(out_data), (n != 0) ? 32'(q[0]) : 32'd0);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(n < 4));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= 3));
    endtask

    task automatic step(input string tag, input logic v, input logic [7:0] d, input logic r);
        logic push;
        logic pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        check_all(tag);
        push = v && (q.size() < 4);
        pop  = r && (q.size() > 0);
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(d);
    endtask

    initial begin
        logic       pv;
        logic [7:0] pd;
        pair_t      pe;

        // Reset state
        #2;
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("post_reset");

        // 1: single push, no pop; visible after the edge
        step("t1_push", 1'b1, 8'hA5, 1'b0);
        step("t1_hold", 1'b0, 8'h00, 1'b0);
        chk("t1.out_data", 32'(out_data), 32'hA5);
        step("t1_pop", 1'b0, 8'h00, 1'b1);

        // 2: fill, then blocked push on full with simultaneous pop
        for (int i = 1; i <= 4; i++) step("t2_fill", 1'b1, 8'(i), 1'b0);
        chk("t2.full_in_ready", 32'(in_ready), 32'd0);
        chk("t2.full_afull", 32'(almost_full), 32'd1);
        step("t2_push_pop", 1'b1, 8'h05, 1'b1);
        chk("t2.after_pop_count", 32'(count), 32'd3);
        step("t2_push5", 1'b1, 8'h05, 1'b0);
        chk("t2.count4", 32'(count), 32'd4);
        while (q.size() > 2) step("t2_drain", 1'b0, 8'h00, 1'b1);

        // 3: steady push+pop at count=2 through pointer wrap
        for (int i = 0; i < 16; i++) step("t3_stream", 1'b1, 8'(i), 1'b1);
        chk("t3.count", 32'(count), 32'd2);
        while (q.size() > 0) step("t3_drain", 1'b0, 8'h00, 1'b1);

        // 5: async reset mid-cycle with contents present
        for (int i = 0; i < 3; i++) step("t5_fill", 1'b1, 8'hC0 + 8'(i), 1'b0);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        check_all("t5_reset");
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("t5_released");

        // 6: contract violation tolerated; latest data is pushed
        for (int i = 0; i < 4; i++) step("t6_fill", 1'b1, 8'h30 + 8'(i), 1'b0);
        step("t6_hold11", 1'b1, 8'h11, 1'b0);
        step("t6_chg22", 1'b1, 8'h22, 1'b1);
        step("t6_push22", 1'b1, 8'h22, 1'b0);
        while (q.size() > 1) step("t6_drain", 1'b0, 8'h00, 1'b1);
        chk("t6.tail", 32'(out_data), 32'h22);
        step("t6_last", 1'b0, 8'h00, 1'b1);

        // Random traffic honouring the producer contract
        pv = 1'b0;
        pd = '0;
        for (int i = 0; i < 300; i++) begin
            if (!(pv && q.size() >= 4)) begin
                pv = ($urandom_range(0, 3) != 0);
                pd = 8'($urandom);
            end
            step("rand", pv, pd, ($urandom_range(0, 2) != 0));
        end
        while (q.size() > 0) step("rand_drain", 1'b0, 8'h00, 1'b1);
        in_valid = 1'b0;
        out_ready = 1'b0;

        // 4: packed struct element type, DEPTH=8
        s_in_valid = 1'b1;
        s_in_data  = '{tag: 4'h9, v: 8'h3C};
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        chk("t4.out_valid", 32'(s_out_valid), 32'd1);
        chk("t4.tag", 32'(s_out_data.tag), 32'h9);
        chk("t4.v", 32'(s_out_data.v), 32'h3C);
        chk("t4.count", 32'(s_count), 32'd1);
        s_out_ready = 1'b1;
        @(posedge clk);
        #1;
        s_out_ready = 1'b0;
        chk("t4.empty", 32'(s_out_valid), 32'd0);
        chk("t4.zero_data", 32'(s_out_data), 32'd0);
        for (int i = 0; i < 8; i++) begin
            pe = pair_t'($urandom);
            sq.push_back(pe);
            s_in_valid = 1'b1;
            s_in_data  = pe;
            @(posedge clk);
            #1;
        end
        s_in_valid = 1'b0;
        chk("t4.full_count", 32'(s_count), 32'd8);
        chk("t4.full_ready", 32'(s_in_ready), 32'd0);
        chk("t4.afull", 32'(s_almost_full), 32'd1);
        s_out_ready = 1'b1;
        while (sq.size() > 0) begin
            pe = sq.pop_front();
            chk("t4.order", 32'(s_out_data), 32'(pe));
            @(posedge clk);
            #1;
        end
        s_out_ready = 1'b0;
        chk("t4.drained", 32'(s_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
